regfile_wb_scheduler: RTL and testbench

Writeback scheduler and hazard scoreboard for the 32x32 integer register file. Arbitrates three result producers (ALU, LSU, MDU) onto the register file's single write port through a registered writeback stage. Tracks destinations of outstanding long-latency operations so the issue stage stalls on RAW/WAW hazards. Sits between the execute units and `regfile`, and drives `reg_write`/`rd`/`write_data` directly.

---
 rtl/regfile_wb_scheduler_pkg.sv | 24 ++
 rtl/regfile_wb_scheduler_scoreboard.sv | 52 +++++
 rtl/regfile_wb_scheduler.sv | 92 +++++++++
 tb/tb_regfile_wb_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared definitions for the writeback scheduler: requester indices, request
// record and the round-robin index helper.
package regfile_wb_scheduler_pkg;

    localparam int WB_ALU    = 0;
    localparam int WB_LSU    = 1;
    localparam int WB_MDU    = 2;
    localparam int WB_NREQ   = 3;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    // Next requester index in round-robin order, wrapping after the MDU.
    function automatic logic [1:0] wb_next_idx(input logic [1:0] idx);
        return (idx >= 2'(WB_NREQ - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Hazard scoreboard: one pending bit per register, set on long-op issue and
// cleared on the regfile commit edge; three lookups include the in-flight write.
module rf_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 set_en,
    input  logic [ADDR_W-1:0]    set_idx,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_idx,
    input  logic [ADDR_W-1:0]    rs1,
    input  logic [ADDR_W-1:0]    rs2,
    input  logic [ADDR_W-1:0]    rd,
    output logic                 hit_rs1,
    output logic                 hit_rs2,
    output logic                 hit_rd,
    output logic [2**ADDR_W-1:0] pending
);

    localparam int NENT = 2**ADDR_W;

    logic [NENT-1:0] pend_q;

    function automatic logic lookup(input logic [ADDR_W-1:0] x,
                                    input logic [NENT-1:0]   pend,
                                    input logic              fwd_en,
                                    input logic [ADDR_W-1:0] fwd_idx);
        return (x != '0) && (pend[x] || (fwd_en && (fwd_idx == x)));
    endfunction

    // Set is checked first so it wins over a same-edge clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= '0;
        end else begin
            pend_q[0] <= 1'b0;
            for (int i = 1; i < NENT; i++) begin
                if (set_en && (set_idx == ADDR_W'(i)))
                    pend_q[i] <= 1'b1;
                else if (clr_en && (clr_idx == ADDR_W'(i)))
                    pend_q[i] <= 1'b0;
            end
        end
    end

    assign hit_rs1 = lookup(rs1, pend_q, clr_en, clr_idx);
    assign hit_rs2 = lookup(rs2, pend_q, clr_en, clr_idx);
    assign hit_rd  = lookup(rd,  pend_q, clr_en, clr_idx);
    assign pending = pend_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: round-robin arbitration of ALU/LSU/MDU results onto the
// single regfile write port, plus issue stall from the hazard scoreboard.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [2:0]             req_valid,
    input  logic [3*ADDR_W-1:0]    req_rd,
    input  logic [3*DATA_W-1:0]    req_data,
    output logic [2:0]             req_ready,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_rs1,
    input  logic [ADDR_W-1:0]      iss_rs2,
    input  logic [ADDR_W-1:0]      iss_rd,
    input  logic                   iss_long,
    output logic                   iss_stall,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [2**ADDR_W-1:0]   pending
);

    logic [1:0]        rr_ptr;
    logic [2:0]        grant;
    logic [1:0]        gnt_idx;
    logic [1:0]        scan_idx;
    logic              grant_any;
    logic [ADDR_W-1:0] gnt_rd;
    logic [DATA_W-1:0] gnt_data;
    logic              hit_rs1, hit_rs2, hit_rd;
    logic              iss_fire;

    // First valid requester starting at rr_ptr wins.
    always_comb begin
        grant    = '0;
        gnt_idx  = 2'd0;
        scan_idx = rr_ptr;
        for (int k = 0; k < WB_NREQ; k++) begin
            if ((grant == '0) && (scan_idx < 2'(WB_NREQ)) && req_valid[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                gnt_idx         = scan_idx;
            end
            scan_idx = wb_next_idx(scan_idx);
        end
    end

    assign grant_any = |grant;
    assign req_ready = grant;
    assign gnt_rd    = req_rd[gnt_idx*ADDR_W +: ADDR_W];
    assign gnt_data  = req_data[gnt_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr   <= 2'(WB_ALU);
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_any) begin
            rr_ptr   <= wb_next_idx(gnt_idx);
            rf_we    <= (gnt_rd != '0);
            rf_waddr <= gnt_rd;
            rf_wdata <= gnt_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk     (clk),
        .resetn  (resetn),
        .set_en  (iss_fire && iss_long && (iss_rd != '0)),
        .set_idx (iss_rd),
        .clr_en  (rf_we),
        .clr_idx (rf_waddr),
        .rs1     (iss_rs1),
        .rs2     (iss_rs2),
        .rd      (iss_rd),
        .hit_rs1 (hit_rs1),
        .hit_rs2 (hit_rs2),
        .hit_rd  (hit_rd),
        .pending (pending)
    );

    // Stall depends only on issue inputs and registered state, never on req_*.
    assign iss_stall = iss_valid && (hit_rs1 || hit_rs2 || hit_rd);
    assign iss_fire  = iss_valid && !iss_stall;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration order, writeback
// timing, scoreboard set/clear/stall and asynchronous reset.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        resetn;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        iss_valid;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_long;
    logic        iss_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    regfile_wb_scheduler dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_long  (iss_long),
        .iss_stall (iss_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] v,
                           input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        req_valid = v;
        req_rd    = {r2, r1, r0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic set_iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic lng);
        iss_valid = v;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
        iss_rd    = rd;
        iss_long  = lng;
    endtask

    // Advance to just after the next active edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  exp_ready [4];
    logic [4:0]  exp_addr  [4];
    logic [31:0] exp_data  [4];

    initial begin
        resetn = 1'b0;
        set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #2;
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Idle after reset, independent read of r5.
        set_iss(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("idle_stall", 64'(iss_stall), 64'd0);
        check("idle_rf_we", 64'(rf_we), 64'd0);
        check("idle_pending", 64'(pending), 64'd0);
        check("idle_ready", 64'(req_ready), 64'd0);
        next_cycle();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Round-robin with all three valid: ALU, LSU, MDU, ALU.
        set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003);
        exp_ready = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_addr  = '{5'd0, 5'd1, 5'd2, 5'd3};
        exp_data  = '{32'h0, 32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rr_ready_%0d", c), 64'(req_ready), 64'(exp_ready[c]));
            if (c > 0) begin
                check($sformatf("rr_we_%0d", c), 64'(rf_we), 64'd1);
                check($sformatf("rr_waddr_%0d", c), 64'(rf_waddr), 64'(exp_addr[c]));
                check($sformatf("rr_wdata_%0d", c), 64'(rf_wdata), 64'(exp_data[c]));
            end
            next_cycle();
        end
        set_req(3'b000, 5'd1, 5'd2, 5'd3, 32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003);
        @(negedge clk);
        check("rr_last_waddr", 64'(rf_waddr), 64'd1);
        check("rr_last_we", 64'(rf_we), 64'd1);
        next_cycle();
        @(negedge clk);
        check("idle_we_low", 64'(rf_we), 64'd0);
        check("idle_waddr_hold", 64'(rf_waddr), 64'd1);
        check("idle_wdata_hold", 64'(rf_wdata), 64'hA0A0_0001);
        next_cycle();

        // Long op to r7 (rr_ptr now at LSU).
        set_iss(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        @(negedge clk);
        check("r7_issue_stall", 64'(iss_stall), 64'd0);
        next_cycle();
        set_iss(1'b1, 5'd0, 5'd7, 5'd0, 1'b0);
        @(negedge clk);
        check("r7_pending", 64'(pending), 64'h80);
        check("r7_raw_stall", 64'(iss_stall), 64'd1);
        next_cycle();
        set_req(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'h1234_5678, 32'h0);
        @(negedge clk);
        check("r7_lsu_ready", 64'(req_ready), 64'b010);
        check("r7_stall_n", 64'(iss_stall), 64'd1);
        next_cycle();
        set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("r7_stall_n1", 64'(iss_stall), 64'd1);
        check("r7_we_n1", 64'(rf_we), 64'd1);
        check("r7_waddr_n1", 64'(rf_waddr), 64'd7);
        check("r7_wdata_n1", 64'(rf_wdata), 64'h1234_5678);
        check("r7_pending_n1", 64'(pending), 64'h80);
        next_cycle();
        @(negedge clk);
        check("r7_stall_n2", 64'(iss_stall), 64'd0);
        check("r7_pending_n2", 64'(pending), 64'd0);
        next_cycle();

        // Long op to r0 is never tracked; LSU result to r0 is consumed silently.
        set_iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        check("r0_issue_stall", 64'(iss_stall), 64'd0);
        next_cycle();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_req(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        check("r0_pending", 64'(pending), 64'd0);
        check("r0_ready", 64'(req_ready), 64'b010);
        next_cycle();
        set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("r0_we", 64'(rf_we), 64'd0);
        check("r0_pending_after", 64'(pending), 64'd0);
        check("r0_ready_drop", 64'(req_ready), 64'd0);
        next_cycle();

        // WAW on r9 (rr_ptr now at MDU).
        set_iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        next_cycle();
        set_iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b0);
        @(negedge clk);
        check("r9_pending", 64'(pending), 64'h200);
        check("r9_waw_stall", 64'(iss_stall), 64'd1);
        iss_rd = 5'd0;
        #1;
        check("r9_rd0_nostall", 64'(iss_stall), 64'd0);
        iss_rd = 5'd9;
        next_cycle();
        set_req(3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h9999_0009);
        @(negedge clk);
        check("r9_mdu_ready", 64'(req_ready), 64'b100);
        check("r9_stall_n", 64'(iss_stall), 64'd1);
        next_cycle();
        set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("r9_stall_n1", 64'(iss_stall), 64'd1);
        check("r9_waddr_n1", 64'(rf_waddr), 64'd9);
        next_cycle();
        @(negedge clk);
        check("r9_stall_n2", 64'(iss_stall), 64'd0);
        check("r9_pending_n2", 64'(pending), 64'd0);
        next_cycle();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Async reset with pending[4] set and a write to r4 in flight (rr_ptr at ALU).
        set_iss(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
        next_cycle();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_req(3'b001, 5'd4, 5'd0, 5'd0, 32'h4444_0004, 32'h0, 32'h0);
        next_cycle();
        set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        #1;
        check("ar_pre_we", 64'(rf_we), 64'd1);
        check("ar_pre_pending", 64'(pending), 64'h10);
        resetn = 1'b0;
        #1;
        check("ar_we", 64'(rf_we), 64'd0);
        check("ar_pending", 64'(pending), 64'd0);
        check("ar_waddr", 64'(rf_waddr), 64'd0);
        resetn = 1'b1;
        set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
        #1;
        check("ar_rr_alu", 64'(req_ready), 64'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
